// File: rtl/tlb_refill_walker.sv
// Two-level page-table walker answering ITLB/DTLB misses.
// Reads PTEs over a req/gnt/rvalid port and returns a one-cycle fill.
module tlb_refill_walker #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        miss_valid,
  input  logic [21:0] miss_vpn,
  output logic        miss_ready,
  input  logic [31:0] ptbr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        fill_valid,
  output logic [21:0] fill_vpn,
  output logic [21:0] fill_ppn,
  output logic        fill_fault,
  output logic        busy
);

  localparam logic [7:0] TO = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, L1_REQ, L1_WAIT, L2_REQ, L2_WAIT, RESP
  } state_t;

  state_t      state, state_n;
  logic [21:0] vpn_q;
  logic [31:0] ptbr_q;
  logic [21:0] base_q;
  logic [7:0]  cnt_q, cnt_n;
  logic        accept;
  logic        ld_l1;
  logic        ld_fill;
  logic [21:0] ppn_n;
  logic        fault_n;
  logic [31:0] l1_addr;
  logic [31:0] l2_addr;
  logic        unused_ok;

  assign accept     = miss_valid && (state == IDLE);
  assign miss_ready = (state == IDLE);
  assign busy       = (state != IDLE);
  assign fill_valid = (state == RESP);
  assign unused_ok  = ^mem_rdata[9:1];

  assign l1_addr = ptbr_q
                 + {19'b0, vpn_q[21:11], 2'b00};
  assign l2_addr = {base_q, 10'b0}
                 + {19'b0, vpn_q[10:0], 2'b00};

  always_comb begin
    state_n  = state;
    cnt_n    = cnt_q;
    mem_req  = 1'b0;
    mem_addr = '0;
    ld_l1    = 1'b0;
    ld_fill  = 1'b0;
    ppn_n    = '0;
    fault_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (miss_valid) state_n = L1_REQ;
      end
      L1_REQ, L2_REQ: begin
        mem_req  = 1'b1;
        mem_addr = (state == L1_REQ) ? l1_addr : l2_addr;
        if (mem_gnt) begin
          state_n = (state == L1_REQ) ? L1_WAIT : L2_WAIT;
          cnt_n   = '0;
        end
      end
      L1_WAIT, L2_WAIT: begin
        // Data arriving on the timeout cycle still takes priority.
        if (mem_rvalid) begin
          if (!mem_rdata[0]) begin
            ld_fill = 1'b1;
            fault_n = 1'b1;
            state_n = RESP;
          end else if (state == L1_WAIT) begin
            ld_l1   = 1'b1;
            state_n = L2_REQ;
          end else begin
            ld_fill = 1'b1;
            ppn_n   = mem_rdata[31:10];
            state_n = RESP;
          end
        end else begin
          cnt_n = cnt_q + 8'd1;
          if (cnt_n == TO) begin
            ld_fill = 1'b1;
            fault_n = 1'b1;
            state_n = RESP;
          end
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt_q      <= '0;
      vpn_q      <= '0;
      ptbr_q     <= '0;
      base_q     <= '0;
      fill_vpn   <= '0;
      fill_ppn   <= '0;
      fill_fault <= 1'b0;
    end else begin
      state <= state_n;
      cnt_q <= cnt_n;
      if (accept) begin
        vpn_q  <= miss_vpn;
        ptbr_q <= ptbr;
      end
      if (ld_l1) base_q <= mem_rdata[31:10];
      if (ld_fill) begin
        fill_vpn   <= vpn_q;
        fill_ppn   <= ppn_n;
        fill_fault <= fault_n;
      end
    end
  end

endmodule

// File: tb/tb_tlb_refill_walker.sv
// Scoreboard bench for tlb_refill_walker.
// Memory responder model, fill monitor, and directed walks.
module tb_tlb_refill_walker;

  localparam int TO = 255;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        miss_valid;
  logic [21:0] miss_vpn;
  logic        miss_ready;
  logic [31:0] ptbr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        fill_valid;
  logic [21:0] fill_vpn;
  logic [21:0] fill_ppn;
  logic        fill_fault;
  logic        busy;

  tlb_refill_walker #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .miss_valid(miss_valid), .miss_vpn(miss_vpn),
    .miss_ready(miss_ready), .ptbr(ptbr),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .fill_valid(fill_valid), .fill_vpn(fill_vpn),
    .fill_ppn(fill_ppn), .fill_fault(fill_fault),
    .busy(busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [21:0] vpn;
    logic [21:0] ppn;
    logic        fault;
    int          at;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  logic [31:0] mem [logic [31:0]];

  int n_chk  = 0;
  int n_fail = 0;
  int n_gnt  = 0;

  int          gnt_wait  = 0;
  logic        drop_en   = 1'b0;
  logic [31:0] drop_addr = '0;
  logic        inject    = 1'b0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h",
               tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Memory responder: grants after gnt_wait cycles, data next cycle.
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          req_cyc = 0;
  initial begin
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(posedge clock);
      #2;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      if (reset) begin
        pend    = 1'b0;
        req_cyc = 0;
      end else if (inject) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FC01;
        inject     = 1'b0;
      end else if (pend) begin
        chk("req_in_wait", mem_req, 0);
        mem_rvalid = 1'b1;
        mem_rdata  = mem.exists(pend_addr)
                   ? mem[pend_addr] : 32'h0;
        pend = 1'b0;
      end else if (mem_req) begin
        if (addr_q.size() == 0) begin
          chk("req_unexp", mem_req, 0);
        end else begin
          chk("mem_addr", mem_addr, addr_q[0]);
        end
        if (req_cyc == gnt_wait) begin
          mem_gnt = 1'b1;
          if (addr_q.size() != 0) void'(addr_q.pop_front());
          pend      = !(drop_en && mem_addr == drop_addr);
          pend_addr = mem_addr;
          req_cyc   = 0;
          n_gnt++;
        end else begin
          req_cyc++;
        end
      end else if (req_cyc != 0) begin
        chk("req_drop", mem_req, 1);
        req_cyc = 0;
      end
    end
  end

  // Fill monitor: pops the scoreboard on every fill pulse.
  exp_t e_mon;
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (fill_valid) begin
        if (exp_q.size() == 0) begin
          chk("fill_unexp", fill_valid, 0);
        end else begin
          e_mon = exp_q.pop_front();
          chk("fill_vpn", fill_vpn, e_mon.vpn);
          chk("fill_ppn", fill_ppn, e_mon.ppn);
          chk("fill_fault", fill_fault, e_mon.fault);
          if (e_mon.at >= 0) chk("fill_cyc", cyc, e_mon.at);
        end
      end
    end
  end

  task automatic send(input logic [21:0] vpn,
                      input logic [31:0] base,
                      input logic [21:0] ppn,
                      input logic        fault,
                      input logic [31:0] a1,
                      input logic [31:0] a2,
                      input logic        two,
                      input int          lat,
                      input logic        want_fill);
    exp_t e;
    int   k;
    miss_valid = 1'b1;
    miss_vpn   = vpn;
    ptbr       = base;
    k = 0;
    while (!miss_ready && k < 1000) begin
      step();
      k++;
    end
    if (!miss_ready) chk("accept_timeout", miss_ready, 1);
    addr_q.push_back(a1);
    if (two) addr_q.push_back(a2);
    if (want_fill) begin
      e.vpn   = vpn;
      e.ppn   = ppn;
      e.fault = fault;
      e.at    = (lat >= 0) ? cyc + lat : -1;
      exp_q.push_back(e);
    end
    step();
    miss_valid = 1'b0;
    miss_vpn   = '0;
    ptbr       = '0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 1000) begin
      step();
      k++;
    end
    if (busy) chk("idle_timeout", busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int g0;
  initial begin
    miss_valid = 1'b0;
    miss_vpn   = '0;
    ptbr       = '0;
    mem[32'h0001_0004] = 32'h0002_0001;
    mem[32'h0002_0004] = 32'h1234_5401;
    mem[32'h0001_0000] = 32'h0003_0001;
    mem[32'h0003_0000] = 32'hABCD_EC01;
    #1;
    chk("rst_fill_valid", fill_valid, 0);
    chk("rst_fill_fault", fill_fault, 0);
    chk("rst_fill_vpn", fill_vpn, 0);
    chk("rst_fill_ppn", fill_ppn, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_miss_ready", miss_ready, 1);
    repeat (3) step();
    reset = 1'b0;

    repeat (3) step();
    chk("idle_ready", miss_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_req", mem_req, 0);
    chk("idle_fill", fill_valid, 0);

    send(22'h000801, 32'h0001_0000, 22'h048D15, 1'b0,
         32'h0001_0004, 32'h0002_0004, 1'b1, 5, 1'b1);
    wait_idle();

    mem[32'h0001_0004] = 32'h0002_0000;
    g0 = n_gnt;
    send(22'h000801, 32'h0001_0000, 22'h0, 1'b1,
         32'h0001_0004, 32'h0, 1'b0, 3, 1'b1);
    wait_idle();
    chk("l1_fault_one_req", n_gnt - g0, 1);
    step();
    chk("hold_vpn", fill_vpn, 22'h000801);
    chk("hold_ppn", fill_ppn, 0);
    chk("hold_fault", fill_fault, 1);
    mem[32'h0001_0004] = 32'h0002_0001;

    gnt_wait = 3;
    send(22'h000801, 32'h0001_0000, 22'h048D15, 1'b0,
         32'h0001_0004, 32'h0002_0004, 1'b1, 11, 1'b1);
    wait_idle();
    gnt_wait = 0;

    send(22'h000801, 32'h0001_0000, 22'h048D15, 1'b0,
         32'h0001_0004, 32'h0002_0004, 1'b1, 5, 1'b1);
    send(22'h000000, 32'h0001_0000, 22'h2AF37B, 1'b0,
         32'h0001_0000, 32'h0003_0000, 1'b1, 5, 1'b1);
    wait_idle();

    drop_en   = 1'b1;
    drop_addr = 32'h0002_0004;
    send(22'h000801, 32'h0001_0000, 22'h0, 1'b1,
         32'h0001_0004, 32'h0002_0004, 1'b1, 4 + TO, 1'b1);
    wait_idle();
    step();
    inject = 1'b1;
    repeat (3) step();
    chk("late_rv_busy", busy, 0);
    chk("late_rv_fill", fill_valid, 0);

    send(22'h000801, 32'h0001_0000, 22'h0, 1'b1,
         32'h0001_0004, 32'h0002_0004, 1'b1, -1, 1'b0);
    repeat (4) step();
    chk("pre_rst_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_req", mem_req, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", miss_ready, 1);
    chk("mid_rst_fill", fill_valid, 0);
    addr_q.delete();
    drop_en = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    step();

    send(22'h000000, 32'h0001_0000, 22'h2AF37B, 1'b0,
         32'h0001_0000, 32'h0003_0000, 1'b1, 5, 1'b1);
    wait_idle();
    repeat (2) step();
    chk("sb_fill_left", exp_q.size(), 0);
    chk("sb_addr_left", addr_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
